// File: rtl/led_pattern_controller.sv
// LED pattern engine with integrated step-rate divider.
// Patterns: bounce, rotate-left, rotate-right, fill bar; speed shifts the period.
// Optional feature macro: BOUNCE_DWELL_EN (bounce holds each end LED one extra step).
module led_pattern_controller #(
    parameter int NUM_LEDS    = 8,
    parameter int TICK_CYCLES = 50_000_000,
    parameter int CNT_W       = 32
) (
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [1:0]          speed,
    output logic [NUM_LEDS-1:0] leds,
    output logic                tick_out,
    output logic                step_pulse,
    output logic                dir
);

    localparam int LVL_W = $clog2(NUM_LEDS + 1);

    typedef enum logic [1:0] {
        M_BOUNCE = 2'b00,
        M_ROTL   = 2'b01,
        M_ROTR   = 2'b10,
        M_FILL   = 2'b11
    } mode_e;

    mode_e               mode_q, mode_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                dir_q, dir_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                pulse_q, pulse_d;

    logic [CNT_W-1:0]    period, limit, half;
    logic [NUM_LEDS-1:0] start_leds, step_leds;
    logic                start_dir, step_dir;
    logic [LVL_W-1:0]    step_level;

    assign period = CNT_W'(TICK_CYCLES) >> speed;
    assign limit  = period - CNT_W'(1);
    assign half   = period >> 1;

    // Start state of the mode currently on the input pins (used on reset and mode change)
    always_comb begin
        start_leds = NUM_LEDS'(1);
        start_dir  = 1'b1;
        case (mode_e'(mode))
            M_ROTR: begin
                start_leds = {1'b1, {(NUM_LEDS-1){1'b0}}};
                start_dir  = 1'b0;
            end
            M_FILL:  start_leds = '0;
            default: ;
        endcase
    end

    // One pattern advance from the current registered state
    always_comb begin
        step_leds  = leds_q;
        step_dir   = dir_q;
        step_level = level_q;
        case (mode_q)
            M_BOUNCE: begin
`ifdef BOUNCE_DWELL_EN
                // At an end, spend one step turning around instead of moving
                if (dir_q) begin
                    if (leds_q[NUM_LEDS-1]) step_dir = 1'b0;
                    else                    step_leds = leds_q << 1;
                end else begin
                    if (leds_q[0]) step_dir = 1'b1;
                    else           step_leds = leds_q >> 1;
                end
`else
                // Reverse on arrival at an end so the end LED shows for one step only
                if (dir_q) begin
                    step_leds = leds_q << 1;
                    if (leds_q[NUM_LEDS-2]) step_dir = 1'b0;
                end else begin
                    step_leds = leds_q >> 1;
                    if (leds_q[1]) step_dir = 1'b1;
                end
`endif
            end
            M_ROTL: step_leds = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
            M_ROTR: step_leds = {leds_q[0], leds_q[NUM_LEDS-1:1]};
            M_FILL: begin
                if (level_q == LVL_W'(NUM_LEDS)) begin
                    step_level = '0;
                    step_leds  = '0;
                end else begin
                    step_level = level_q + LVL_W'(1);
                    step_leds  = {leds_q[NUM_LEDS-2:0], 1'b1};
                end
            end
            default: ;
        endcase
    end

    // Next state: mode change beats a step; enable gates counting and advancing
    always_comb begin
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        leds_d  = leds_q;
        dir_d   = dir_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (mode_e'(mode) != mode_q) begin
            mode_d  = mode_e'(mode);
            cnt_d   = '0;
            leds_d  = start_leds;
            dir_d   = start_dir;
            level_d = '0;
        end else if (enable) begin
            if (cnt_q >= limit) begin
                cnt_d   = '0;
                pulse_d = 1'b1;
                leds_d  = step_leds;
                dir_d   = step_dir;
                level_d = step_level;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset loading the selected mode's start state
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            mode_q  <= mode_e'(mode);
            cnt_q   <= '0;
            leds_q  <= start_leds;
            dir_q   <= start_dir;
            level_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
            dir_q   <= dir_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign leds       = leds_q;
    assign dir        = dir_q;
    assign step_pulse = pulse_q;
    assign tick_out   = (cnt_q >= half);

endmodule

// File: tb/tb_led_pattern_controller.sv
// Self-checking bench for led_pattern_controller (NUM_LEDS=8, TICK_CYCLES=16).
module tb_led_pattern_controller;

    localparam int N    = 8;
    localparam int TICK = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [1:0]   speed = 2'b00;
    logic [N-1:0] leds;
    logic         tick_out, step_pulse, dir;

    led_pattern_controller #(.NUM_LEDS(N), .TICK_CYCLES(TICK), .CNT_W(32)) dut (
        .clk_in(clk), .reset_n(rst_n), .enable(en), .mode(mode), .speed(speed),
        .leds(leds), .tick_out(tick_out), .step_pulse(step_pulse), .dir(dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst_n, en;
        bit [1:0]   mode, speed;
        int         cycles;
        logic [7:0] leds;
        bit         dir, pulse, tick;
    } vec_t;

    typedef struct {
        logic [7:0] leds;
        bit         dir, pulse, tick;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    // Reference model state
    int       m_cnt, m_pos, m_lvl;
    bit       m_dir, m_pulse;
    bit [1:0] m_mode;

    function automatic vec_t mk(bit r, bit e, bit [1:0] m, bit [1:0] s, int c,
                                logic [7:0] l, bit d, bit p, bit t);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.speed = s; v.cycles = c;
        v.leds = l; v.dir = d; v.pulse = p; v.tick = t;
        return v;
    endfunction

    task automatic m_load();
        m_mode = mode;
        m_cnt = 0; m_pulse = 0; m_lvl = 0;
        case (mode)
            2'b10:   begin m_pos = N - 1; m_dir = 0; end
            default: begin m_pos = 0;     m_dir = 1; end
        endcase
    endtask

    task automatic m_advance();
        case (m_mode)
            2'b00: begin
`ifdef BOUNCE_DWELL_EN
                if (m_dir) begin if (m_pos == N - 1) m_dir = 0; else m_pos++; end
                else       begin if (m_pos == 0) m_dir = 1; else m_pos--; end
`else
                if (m_dir) begin m_pos++; if (m_pos == N - 1) m_dir = 0; end
                else       begin m_pos--; if (m_pos == 0) m_dir = 1; end
`endif
            end
            2'b01: m_pos = (m_pos + 1) % N;
            2'b10: m_pos = (m_pos + N - 1) % N;
            default: m_lvl = (m_lvl == N) ? 0 : m_lvl + 1;
        endcase
    endtask

    function automatic exp_t m_out();
        exp_t e;
        int p;
        p = TICK >> speed;
        if (m_mode == 2'b11) e.leds = 8'(((1 << m_lvl) - 1));
        else                 e.leds = 8'((1 << m_pos));
        e.dir = m_dir; e.pulse = m_pulse; e.tick = (m_cnt >= (p >> 1));
        return e;
    endfunction

    // One clock: model predicts, scoreboard holds the prediction until DUT output is sampled
    task automatic cycle();
        exp_t e;
        int   p;
        p = TICK >> speed;
        if (!rst_n || mode != m_mode) m_load();
        else if (en) begin
            if (m_cnt >= p - 1) begin m_cnt = 0; m_pulse = 1; m_advance(); end
            else begin m_cnt++; m_pulse = 0; end
        end else m_pulse = 0;
        sb.push_back(m_out());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        nvec++;
        if (leds !== e.leds || dir !== e.dir || step_pulse !== e.pulse || tick_out !== e.tick) begin
            nerr++;
            $display("FAIL cycle@%0t: got leds=%h dir=%b pulse=%b tick=%b, want leds=%h dir=%b pulse=%b tick=%b",
                     $time, leds, dir, step_pulse, tick_out, e.leds, e.dir, e.pulse, e.tick);
        end
    endtask

    initial begin
        tbl.push_back(mk(0,1,2'b00,0,   1, 8'h01,1,0,0)); // reset into bounce
        tbl.push_back(mk(1,1,2'b00,0,   8, 8'h01,1,0,1)); // counter 8: tick high
        tbl.push_back(mk(1,1,2'b00,0,   8, 8'h02,1,1,0)); // first step after 16
`ifdef BOUNCE_DWELL_EN
        tbl.push_back(mk(1,1,2'b00,0,  96, 8'h80,1,1,0));
        tbl.push_back(mk(1,1,2'b00,0, 112, 8'h02,0,1,0));
`else
        tbl.push_back(mk(1,1,2'b00,0,  96, 8'h80,0,1,0)); // dir falls at MSB
        tbl.push_back(mk(1,1,2'b00,0, 112, 8'h01,1,1,0)); // back at LSB, dir rises
`endif
        tbl.push_back(mk(1,1,2'b01,0,   1, 8'h01,1,0,0)); // mode -> ROT_L
        tbl.push_back(mk(1,1,2'b01,0, 160, 8'h04,1,1,0)); // 10 steps with wrap
        tbl.push_back(mk(1,1,2'b01,0,   5, 8'h04,1,0,0));
        tbl.push_back(mk(1,1,2'b10,0,   1, 8'h80,0,0,0)); // mode -> ROT_R mid-period
        tbl.push_back(mk(1,1,2'b10,0,  48, 8'h10,0,1,0));
        tbl.push_back(mk(1,1,2'b10,0,  80, 8'h80,0,1,0)); // LSB wraps to MSB
        tbl.push_back(mk(1,1,2'b11,0,   1, 8'h00,1,0,0)); // mode -> FILL
        tbl.push_back(mk(1,1,2'b11,0, 128, 8'hFF,1,1,0));
        tbl.push_back(mk(1,1,2'b11,0,  16, 8'h00,1,1,0)); // full bar returns to empty
        tbl.push_back(mk(1,1,2'b11,0,  48, 8'h07,1,1,0));
        tbl.push_back(mk(1,1,2'b11,0,  10, 8'h07,1,0,1)); // counter 10
        tbl.push_back(mk(1,1,2'b11,3,   1, 8'h0F,1,1,0)); // speed 3: immediate step
        tbl.push_back(mk(1,1,2'b11,3,   1, 8'h0F,1,0,1));
        tbl.push_back(mk(1,1,2'b11,3,   1, 8'h1F,1,1,0)); // step every 2 cycles
        tbl.push_back(mk(1,1,2'b11,0,   9, 8'h1F,1,0,1));
        tbl.push_back(mk(1,0,2'b11,0,  40, 8'h1F,1,0,1)); // frozen
        tbl.push_back(mk(1,1,2'b11,0,   6, 8'h1F,1,0,1));
        tbl.push_back(mk(1,1,2'b11,0,   1, 8'h3F,1,1,0)); // period completes
        tbl.push_back(mk(1,0,2'b10,0,   1, 8'h80,0,0,0)); // mode change while disabled
        tbl.push_back(mk(1,1,2'b10,0,  32, 8'h20,0,1,0));
        tbl.push_back(mk(1,1,2'b10,0,   5, 8'h20,0,0,0));
        tbl.push_back(mk(0,1,2'b10,0,   1, 8'h80,0,0,0)); // reset mid-pattern
        tbl.push_back(mk(1,1,2'b10,0,  16, 8'h40,0,1,0));
        tbl.push_back(mk(1,1,2'b10,0,  15, 8'h40,0,0,1)); // counter at limit
        tbl.push_back(mk(1,1,2'b00,0,   1, 8'h01,1,0,0)); // mode change beats step
        tbl.push_back(mk(1,1,2'b00,0,  16, 8'h02,1,1,0));
        tbl.push_back(mk(1,1,2'b00,1,   4, 8'h02,1,0,1)); // speed 1: half = 4
        tbl.push_back(mk(1,1,2'b00,1,   4, 8'h04,1,1,0));

        m_mode = 2'b00; m_cnt = 0; m_pos = 0; m_lvl = 0; m_dir = 1; m_pulse = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst_n; en = tbl[i].en; mode = tbl[i].mode; speed = tbl[i].speed;
            for (int c = 0; c < tbl[i].cycles; c++) cycle();
            nvec++;
            if (leds !== tbl[i].leds || dir !== tbl[i].dir ||
                step_pulse !== tbl[i].pulse || tick_out !== tbl[i].tick) begin
                nerr++;
                $display("FAIL phase %0d: got leds=%h dir=%b pulse=%b tick=%b, want leds=%h dir=%b pulse=%b tick=%b",
                         i, leds, dir, step_pulse, tick_out,
                         tbl[i].leds, tbl[i].dir, tbl[i].pulse, tbl[i].tick);
            end
        end

        // One-hot invariant over a long bounce run at top speed
        rst_n = 1; en = 1; mode = 2'b00; speed = 2'b11;
        for (int c = 0; c < 64; c++) begin
            cycle();
            nvec++;
            if ($countones(leds) != 1) begin
                nerr++;
                $display("FAIL onehot: got leds=%h, want exactly one bit set", leds);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
